// File: rtl/retry_requester.sv
// Initiator-side QoS retry agent: issues local commands as retry-allowed requests,
// tracks acks and parked slots, and resends the oldest parked slot on each grant.
module retry_requester #(
  parameter int SRC_NODE_W = 2,
  parameter int NODE_ID    = 0,
  parameter int PAYLD_BW   = 8,
  parameter int OST_NUM    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      vld_cmd_in,
  output logic                      rdy_cmd_in,
  input  logic [3:0]                cmd_qos,
  input  logic [PAYLD_BW-1:0]       cmd_payload,
  output logic                      vld_req_out,
  input  logic                      rdy_req_out,
  output logic                      req_type_out,
  output logic [3:0]                qos_out,
  output logic [SRC_NODE_W-1:0]     src_id_out,
  output logic [PAYLD_BW-1:0]       payload_out,
  input  logic                      vld_ack_in,
  input  logic                      ack_retry,
  input  logic                      vld_grant_in,
  output logic                      rdy_grant_in,
  input  logic [3:0]                grant_des_id,
  output logic                      done_pulse,
  output logic [$clog2(OST_NUM):0]  ost_cnt,
  output logic                      err_ack,
  output logic                      err_grant
);

  localparam int IW = $clog2(OST_NUM);
  localparam int CW = IW + 1;
  localparam logic [IW:0] PTR_ONE = 1;

  localparam logic [2:0] ST_FREE        = 3'd0;
  localparam logic [2:0] ST_PEND_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK    = 3'd2;
  localparam logic [2:0] ST_PARKED      = 3'd3;
  localparam logic [2:0] ST_PEND_RESEND = 3'd4;

  logic [2:0]          r_state   [OST_NUM];
  logic [3:0]          r_qos     [OST_NUM];
  logic [PAYLD_BW-1:0] r_payload [OST_NUM];
  logic [OST_NUM-1:0]  r_rtype;

  logic [IW-1:0] r_ackq [OST_NUM];
  logic [IW-1:0] r_pkq  [OST_NUM];
  logic [IW-1:0] r_rsq  [OST_NUM];
  logic [IW:0]   r_ackq_wp, r_ackq_rp, r_pkq_wp, r_pkq_rp, r_rsq_wp, r_rsq_rp;

  logic                r_init;
  logic                r_pi_vld;
  logic [IW-1:0]       r_pi_idx;
  logic                r_vld;
  logic                r_out_rt;
  logic [3:0]          r_out_qos;
  logic [PAYLD_BW-1:0] r_out_pl;
  logic [IW-1:0]       r_out_idx;
  logic                r_done;
  logic [CW-1:0]       r_cnt;
  logic                r_err_ack;
  logic                r_err_grant;

  logic          w_ack_empty, w_pk_empty, w_rs_empty;
  logic [IW-1:0] w_ack_head, w_pk_head, w_rs_head;
  logic          w_free_any, w_pi_any;
  logic [IW-1:0] w_free_idx;
  logic          w_cmd_hs, w_req_hs, w_out_free;
  logic          w_ld_rs, w_ld_pi, w_ld_cmd;
  logic          w_ack_do, w_ack_free, w_ack_park, w_ack_bad, w_ack_orphan;
  logic          w_gnt_match, w_gnt_pop, w_gnt_byp, w_gnt_err, w_gnt_do;
  logic [IW-1:0] w_gnt_idx;
  logic          w_pk_push;
  logic [2:0]    w_state_nxt [OST_NUM];
  logic [CW-1:0] w_cnt_nxt;
  logic          w_unused_des;

  assign w_ack_empty = (r_ackq_wp == r_ackq_rp);
  assign w_pk_empty  = (r_pkq_wp == r_pkq_rp);
  assign w_rs_empty  = (r_rsq_wp == r_rsq_rp);
  assign w_ack_head  = r_ackq[r_ackq_rp[IW-1:0]];
  assign w_pk_head   = r_pkq[r_pkq_rp[IW-1:0]];
  assign w_rs_head   = r_rsq[r_rsq_rp[IW-1:0]];

  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    w_pi_any   = 1'b0;
    for (int unsigned i = 0; i < OST_NUM; i++) begin
      if (r_state[OST_NUM-1-i] == ST_FREE) begin
        w_free_any = 1'b1;
        w_free_idx = IW'(OST_NUM-1-i);
      end
      if (r_state[i] == ST_PEND_ISSUE) w_pi_any = 1'b1;
    end
  end

  assign rdy_cmd_in = r_init && w_free_any && !w_pi_any;
  assign w_cmd_hs   = vld_cmd_in && rdy_cmd_in;
  assign w_req_hs   = r_vld && rdy_req_out;
  assign w_out_free = !r_vld || rdy_req_out;

  // Resends win; a fresh command bypasses the slot table straight into the output register.
  assign w_ld_rs  = w_out_free && !w_rs_empty;
  assign w_ld_pi  = w_out_free && w_rs_empty && r_pi_vld;
  assign w_ld_cmd = w_out_free && w_rs_empty && !r_pi_vld && w_cmd_hs;

  assign w_ack_do     = vld_ack_in && !w_ack_empty;
  assign w_ack_orphan = vld_ack_in && w_ack_empty;
  assign w_ack_free   = w_ack_do && !ack_retry;
  assign w_ack_park   = w_ack_do && ack_retry && r_rtype[w_ack_head];
  assign w_ack_bad    = w_ack_do && ack_retry && !r_rtype[w_ack_head];

  assign w_gnt_match = vld_grant_in && (grant_des_id[SRC_NODE_W-1:0] == SRC_NODE_W'(NODE_ID));
  assign w_gnt_pop   = w_gnt_match && !w_pk_empty;
  // A slot parked this very cycle satisfies a grant that finds the park FIFO empty.
  assign w_gnt_byp   = w_gnt_match && w_pk_empty && w_ack_park;
  assign w_gnt_err   = w_gnt_match && w_pk_empty && !w_ack_park;
  assign w_gnt_do    = w_gnt_pop || w_gnt_byp;
  assign w_gnt_idx   = w_gnt_byp ? w_ack_head : w_pk_head;
  assign w_pk_push   = w_ack_park && !w_gnt_byp;

  always_comb begin
    w_cnt_nxt = '0;
    for (int unsigned i = 0; i < OST_NUM; i++) begin
      w_state_nxt[i] = r_state[i];
      if (w_cmd_hs && (w_free_idx == IW'(i))) w_state_nxt[i] = ST_PEND_ISSUE;
      if (w_req_hs && (r_out_idx == IW'(i)))  w_state_nxt[i] = ST_WAIT_ACK;
      if (w_ack_do && (w_ack_head == IW'(i))) w_state_nxt[i] = w_ack_park ? ST_PARKED : ST_FREE;
      if (w_gnt_do && (w_gnt_idx == IW'(i)))  w_state_nxt[i] = ST_PEND_RESEND;
      if (w_state_nxt[i] != ST_FREE) w_cnt_nxt = w_cnt_nxt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init <= 1'b0;
      for (int unsigned i = 0; i < OST_NUM; i++) begin
        r_state[i]   <= ST_FREE;
        r_qos[i]     <= '0;
        r_payload[i] <= '0;
        r_ackq[i]    <= '0;
        r_pkq[i]     <= '0;
        r_rsq[i]     <= '0;
      end
      r_rtype     <= '0;
      r_ackq_wp   <= '0;
      r_ackq_rp   <= '0;
      r_pkq_wp    <= '0;
      r_pkq_rp    <= '0;
      r_rsq_wp    <= '0;
      r_rsq_rp    <= '0;
      r_pi_vld    <= 1'b0;
      r_pi_idx    <= '0;
      r_vld       <= 1'b0;
      r_out_rt    <= 1'b0;
      r_out_qos   <= '0;
      r_out_pl    <= '0;
      r_out_idx   <= '0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_err_ack   <= 1'b0;
      r_err_grant <= 1'b0;
    end else begin
      r_init <= 1'b1;
      for (int unsigned i = 0; i < OST_NUM; i++) r_state[i] <= w_state_nxt[i];

      if (w_cmd_hs) begin
        r_qos[w_free_idx]     <= cmd_qos;
        r_payload[w_free_idx] <= cmd_payload;
        r_rtype[w_free_idx]   <= 1'b1;
      end
      if (w_gnt_do) r_rtype[w_gnt_idx] <= 1'b0;

      if (w_req_hs) begin
        r_ackq[r_ackq_wp[IW-1:0]] <= r_out_idx;
        r_ackq_wp <= r_ackq_wp + PTR_ONE;
      end
      if (w_ack_do) r_ackq_rp <= r_ackq_rp + PTR_ONE;

      if (w_pk_push) begin
        r_pkq[r_pkq_wp[IW-1:0]] <= w_ack_head;
        r_pkq_wp <= r_pkq_wp + PTR_ONE;
      end
      if (w_gnt_pop) r_pkq_rp <= r_pkq_rp + PTR_ONE;

      if (w_gnt_do) begin
        r_rsq[r_rsq_wp[IW-1:0]] <= w_gnt_idx;
        r_rsq_wp <= r_rsq_wp + PTR_ONE;
      end
      if (w_ld_rs) r_rsq_rp <= r_rsq_rp + PTR_ONE;

      if (w_cmd_hs && !w_ld_cmd) begin
        r_pi_vld <= 1'b1;
        r_pi_idx <= w_free_idx;
      end else if (w_ld_pi) begin
        r_pi_vld <= 1'b0;
      end

      if (w_ld_rs) begin
        r_vld     <= 1'b1;
        r_out_rt  <= 1'b0;
        r_out_qos <= r_qos[w_rs_head];
        r_out_pl  <= r_payload[w_rs_head];
        r_out_idx <= w_rs_head;
      end else if (w_ld_pi) begin
        r_vld     <= 1'b1;
        r_out_rt  <= 1'b1;
        r_out_qos <= r_qos[r_pi_idx];
        r_out_pl  <= r_payload[r_pi_idx];
        r_out_idx <= r_pi_idx;
      end else if (w_ld_cmd) begin
        r_vld     <= 1'b1;
        r_out_rt  <= 1'b1;
        r_out_qos <= cmd_qos;
        r_out_pl  <= cmd_payload;
        r_out_idx <= w_free_idx;
      end else if (w_req_hs) begin
        r_vld <= 1'b0;
      end

      r_done      <= w_ack_free;
      r_cnt       <= w_cnt_nxt;
      r_err_ack   <= r_err_ack | w_ack_bad | w_ack_orphan;
      r_err_grant <= r_err_grant | w_gnt_err;
    end
  end

  assign w_unused_des = ^grant_des_id;

  assign vld_req_out  = r_vld;
  assign req_type_out = r_out_rt;
  assign qos_out      = r_out_qos;
  assign payload_out  = r_out_pl;
  assign src_id_out   = SRC_NODE_W'(NODE_ID);
  assign rdy_grant_in = 1'b1;
  assign done_pulse   = r_done;
  assign ost_cnt      = r_cnt;
  assign err_ack      = r_err_ack;
  assign err_grant    = r_err_grant;

endmodule

// File: tb/tb_retry_requester.sv
// Scoreboard bench for retry_requester: directed stimulus pushes expected requests and
// done pulses into queues; a negedge monitor pops and compares whenever the DUT presents one.
module tb_retry_requester;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld_cmd_in = 1'b0;
  logic       rdy_cmd_in;
  logic [3:0] cmd_qos = '0;
  logic [7:0] cmd_payload = '0;
  logic       vld_req_out;
  logic       rdy_req_out = 1'b1;
  logic       req_type_out;
  logic [3:0] qos_out;
  logic [1:0] src_id_out;
  logic [7:0] payload_out;
  logic       vld_ack_in = 1'b0;
  logic       ack_retry = 1'b0;
  logic       vld_grant_in = 1'b0;
  logic       rdy_grant_in;
  logic [3:0] grant_des_id = '0;
  logic       done_pulse;
  logic [2:0] ost_cnt;
  logic       err_ack;
  logic       err_grant;

  always #5 clk = ~clk;

  retry_requester #(
    .SRC_NODE_W (2),
    .NODE_ID    (0),
    .PAYLD_BW   (8),
    .OST_NUM    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld_cmd_in   (vld_cmd_in),
    .rdy_cmd_in   (rdy_cmd_in),
    .cmd_qos      (cmd_qos),
    .cmd_payload  (cmd_payload),
    .vld_req_out  (vld_req_out),
    .rdy_req_out  (rdy_req_out),
    .req_type_out (req_type_out),
    .qos_out      (qos_out),
    .src_id_out   (src_id_out),
    .payload_out  (payload_out),
    .vld_ack_in   (vld_ack_in),
    .ack_retry    (ack_retry),
    .vld_grant_in (vld_grant_in),
    .rdy_grant_in (rdy_grant_in),
    .grant_des_id (grant_des_id),
    .done_pulse   (done_pulse),
    .ost_cnt      (ost_cnt),
    .err_ack      (err_ack),
    .err_grant    (err_grant)
  );

  typedef struct packed {
    logic       rt;
    logic [3:0] qos;
    logic [7:0] pl;
  } req_t;

  req_t exp_q[$];
  int   done_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  req_t mon_e;

  always @(negedge clk) begin
    if (rst_n && vld_req_out && rdy_req_out) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL req_unexpected: got rt=%0d qos=%0h pl=%0h, required no request",
                 req_type_out, qos_out, payload_out);
      end else begin
        mon_e = exp_q.pop_front();
        if ({req_type_out, qos_out, payload_out} !== mon_e) begin
          n_err++;
          $display("FAIL req_data: got rt=%0d qos=%0h pl=%0h, required rt=%0d qos=%0h pl=%0h",
                   req_type_out, qos_out, payload_out, mon_e.rt, mon_e.qos, mon_e.pl);
        end
      end
    end
    if (rst_n && done_pulse) begin
      n_vec++;
      if (done_q.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: got done_pulse=1, required 0");
      end else begin
        void'(done_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] q, input logic [7:0] p);
    logic hs;
    hs = 1'b0;
    vld_cmd_in  = 1'b1;
    cmd_qos     = q;
    cmd_payload = p;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      hs = rdy_cmd_in;
      step();
      if (hs) break;
    end
    vld_cmd_in = 1'b0;
    if (!hs) chk("cmd_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_ack(input logic retry);
    vld_ack_in = 1'b1;
    ack_retry  = retry;
    step();
    vld_ack_in = 1'b0;
    ack_retry  = 1'b0;
  endtask

  task automatic do_grant(input logic [3:0] des);
    vld_grant_in = 1'b1;
    grant_des_id = des;
    step();
    vld_grant_in = 1'b0;
    grant_des_id = '0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {vld_req_out, req_type_out, qos_out, payload_out, done_pulse, err_ack, err_grant},
        '0);
    chk("rst_ost_cnt", ost_cnt, 0);
    chk("rst_rdy_grant", rdy_grant_in, 1);
    chk("src_id", src_id_out, 0);
    step();
    @(negedge clk);
    chk("rdy_cmd_after_rst", rdy_cmd_in, 1);
    step();

    // Single command accepted
    exp_q.push_back('{rt: 1'b1, qos: 4'h3, pl: 8'hA5});
    send_cmd(4'h3, 8'hA5);
    @(negedge clk);
    chk("t1_ost_busy", ost_cnt, 1);
    step();
    drain("t1_drain");
    done_q.push_back(1);
    do_ack(1'b0);
    @(negedge clk);
    chk("t1_ost_free", ost_cnt, 0);
    step();
    chk("t1_done_seen", done_q.size(), 0);

    // Parked then granted
    exp_q.push_back('{rt: 1'b1, qos: 4'h3, pl: 8'hA5});
    send_cmd(4'h3, 8'hA5);
    drain("t2_drain1");
    do_ack(1'b1);
    @(negedge clk);
    chk("t2_ost_parked", ost_cnt, 1);
    step();
    exp_q.push_back('{rt: 1'b0, qos: 4'h3, pl: 8'hA5});
    do_grant(4'h0);
    @(negedge clk);
    chk("t2_no_req_yet", vld_req_out, 0);
    step();
    @(negedge clk);
    chk("t2_resend_2cyc", {vld_req_out, req_type_out, payload_out}, {1'b1, 1'b0, 8'hA5});
    step();
    drain("t2_drain2");
    done_q.push_back(2);
    do_ack(1'b0);
    step();
    chk("t2_done_seen", done_q.size(), 0);
    chk("t2_ost_free", ost_cnt, 0);

    // Fill all slots, park all, then resend in park order
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{rt: 1'b1, qos: 4'(i + 1), pl: 8'(8'h10 + i)});
      send_cmd(4'(i + 1), 8'(8'h10 + i));
      drain("t3_fill_drain");
      do_ack(1'b1);
    end
    @(negedge clk);
    chk("t3_ost_full", ost_cnt, 4);
    chk("t3_rdy_cmd_full", rdy_cmd_in, 0);
    step();
    vld_cmd_in  = 1'b1;
    cmd_qos     = 4'hF;
    cmd_payload = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_fifth_blocked", rdy_cmd_in, 0);
      step();
    end
    vld_cmd_in = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{rt: 1'b0, qos: 4'(i + 1), pl: 8'(8'h10 + i)});
    for (int i = 0; i < 4; i++) do_grant(4'h0);
    drain("t3_resend_drain");
    for (int i = 0; i < 4; i++) begin
      done_q.push_back(10 + i);
      do_ack(1'b0);
    end
    step();
    chk("t3_done_seen", done_q.size(), 0);
    chk("t3_ost_free", ost_cnt, 0);

    // Non-matching grant ignored, matching grant with nothing parked flags
    do_grant(4'h1);
    @(negedge clk);
    chk("t4_nonmatch_no_err", err_grant, 0);
    step();
    do_grant(4'h4);
    @(negedge clk);
    chk("t4_hi_bits_ignored_err", err_grant, 1);
    step();
    repeat (3) step();
    @(negedge clk);
    chk("t4_err_sticky_noreq", {err_grant, vld_req_out}, {1'b1, 1'b0});
    step();

    // Resend and new command pending under backpressure
    exp_q.push_back('{rt: 1'b1, qos: 4'h5, pl: 8'h3C});
    send_cmd(4'h5, 8'h3C);
    drain("t5_drain1");
    do_ack(1'b1);
    rdy_req_out = 1'b0;
    exp_q.push_back('{rt: 1'b0, qos: 4'h5, pl: 8'h3C});
    exp_q.push_back('{rt: 1'b1, qos: 4'h6, pl: 8'h77});
    do_grant(4'h0);
    send_cmd(4'h6, 8'h77);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_hold_resend", {vld_req_out, req_type_out, qos_out, payload_out},
          {1'b1, 1'b0, 4'h5, 8'h3C});
      step();
    end
    rdy_req_out = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t5_new_next", {vld_req_out, req_type_out, qos_out, payload_out},
        {1'b1, 1'b1, 4'h6, 8'h77});
    step();
    drain("t5_drain2");
    chk("t5_ost_two", ost_cnt, 2);

    // ack_retry on a guaranteed resend
    do_ack(1'b1);
    @(negedge clk);
    chk("t6_err_ack", err_ack, 1);
    chk("t6_ost_dec", ost_cnt, 1);
    step();
    done_q.push_back(20);
    do_ack(1'b0);
    step();
    chk("t6_done_seen", done_q.size(), 0);
    chk("t6_ost_free", ost_cnt, 0);

    // Asynchronous reset mid-burst
    rdy_req_out = 1'b0;
    send_cmd(4'h1, 8'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_rst", {vld_req_out, req_type_out, qos_out, payload_out, done_pulse, err_ack, err_grant},
        '0);
    chk("t7_rst_ost", ost_cnt, 0);
    chk("t7_rst_rdy_grant", rdy_grant_in, 1);
    rdy_req_out = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Same-cycle ack park and grant with empty park FIFO
    exp_q.push_back('{rt: 1'b1, qos: 4'h7, pl: 8'h99});
    send_cmd(4'h7, 8'h99);
    drain("t8_drain1");
    exp_q.push_back('{rt: 1'b0, qos: 4'h7, pl: 8'h99});
    vld_ack_in   = 1'b1;
    ack_retry    = 1'b1;
    vld_grant_in = 1'b1;
    grant_des_id = 4'h0;
    step();
    vld_ack_in   = 1'b0;
    ack_retry    = 1'b0;
    vld_grant_in = 1'b0;
    @(negedge clk);
    chk("t8_bypass_no_err", err_grant, 0);
    step();
    drain("t8_drain2");
    done_q.push_back(30);
    do_ack(1'b0);
    step();
    chk("t8_done_seen", done_q.size(), 0);
    chk("t8_clean", {err_ack, err_grant, ost_cnt}, '0);

    // Ack with nothing outstanding
    do_ack(1'b0);
    @(negedge clk);
    chk("t9_orphan_ack", err_ack, 1);
    step();
    repeat (2) step();
    chk("t9_no_leftover", exp_q.size() + done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
